// File: rtl/clk_sched_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package clk_sched_pkg;

    localparam int DEFAULT_DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } sched_state_t;

endpackage

// File: rtl/clk_sched_channel.sv
// One tick channel: shadow/active divisor, counter and registered tick.
// Optional clk_sq toggle output when CLK_SCHED_SQUARE_EN is defined.
module clk_sched_channel
    import clk_sched_pkg::*;
#(
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             run,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    output logic             tick
`ifdef CLK_SCHED_SQUARE_EN
    ,
    output logic             clk_sq
`endif
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [DIV_W-1:0] shadow_q, shadow_eff;
    logic             tick_n;

    // tick is a flop holding "next cycle's counter sits at div-1", so the
    // pulse lands in the same cycle the counter reads div-1.
    always_comb begin
        shadow_eff = wr_en ? wr_div : shadow_q;
        cnt_n      = '0;
        div_n      = div_q;
        if (arm) begin
            div_n = shadow_q;
        end else if (run) begin
            if (div_q == '0 || cnt_q == div_q - ONE) begin
                div_n = shadow_eff;
            end else begin
                cnt_n = cnt_q + ONE;
            end
        end
        tick_n = (arm || run) && (div_n != '0) && (cnt_n == div_n - ONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            div_q    <= RST_DIV;
            shadow_q <= RST_DIV;
            tick     <= 1'b0;
        end else begin
            cnt_q <= cnt_n;
            div_q <= div_n;
            tick  <= tick_n;
            if (wr_en) begin
                shadow_q <= wr_div;
            end
        end
    end

`ifdef CLK_SCHED_SQUARE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sq <= 1'b0;
        end else if (!(arm || run)) begin
            clk_sq <= 1'b0;
        end else if (tick) begin
            clk_sq <= ~clk_sq;
        end
    end
`endif

endmodule

// File: rtl/clk_enable_scheduler.sv
// Multi-channel clock-enable scheduler: start/stop FSM, config decode, channel array.
// Define CLK_SCHED_SQUARE_EN to add the clk_sq square-wave outputs.
module clk_enable_scheduler
    import clk_sched_pkg::*;
#(
    parameter int   NUM_CH      = 4,
    parameter int   DIV_W       = DEFAULT_DIV_W,
    parameter int   DEFAULT_DIV = 10,
    localparam int  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              start,
    input  logic              stop,
    output logic              running,
    output logic [NUM_CH-1:0] tick
`ifdef CLK_SCHED_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] clk_sq
`endif
);

    sched_state_t state_q, state_n;
    logic         arm;
    logic         run_cont;
    logic         cfg_hs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Channels see "RUN continues into next cycle" so a stop clears them on the same edge.
    always_comb begin
        state_n   = state_q;
        cfg_ready = 1'b1;
        running   = 1'b0;
        arm       = 1'b0;
        run_cont  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_n = ARM;
                end
            end
            ARM: begin
                cfg_ready = 1'b0;
                arm       = 1'b1;
                state_n   = RUN;
            end
            RUN: begin
                running  = 1'b1;
                run_cont = !stop;
                if (stop) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign cfg_hs = cfg_valid && cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);

        clk_sched_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .arm    (arm),
            .run    (run_cont),
            .wr_en  (cfg_hs && (cfg_ch == IDX)),
            .wr_div (cfg_div),
            .tick   (tick[i])
`ifdef CLK_SCHED_SQUARE_EN
            ,
            .clk_sq (clk_sq[i])
`endif
        );
    end

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Scoreboard bench for clk_enable_scheduler; square-wave test runs when CLK_SCHED_SQUARE_EN is defined.
module tb_clk_enable_scheduler;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              start;
    logic              stop;
    logic              running;
    logic [NUM_CH-1:0] tick;
`ifdef CLK_SCHED_SQUARE_EN
    logic [NUM_CH-1:0] clk_sq;
`endif

    int checks   = 0;
    int failures = 0;
    logic [NUM_CH-1:0] exp_q[$];

    clk_enable_scheduler #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .start     (start),
        .stop      (stop),
        .running   (running),
        .tick      (tick)
`ifdef CLK_SCHED_SQUARE_EN
        ,
        .clk_sq    (clk_sq)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench observing the ARM cycle.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [DIV_W-1:0] div);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [NUM_CH-1:0] exp;
        reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; start = 1'b0; stop = 1'b0;
        step(); step();
        checks++; if (tick !== '0) begin failures++; $display("FAIL reset_tick got=%b want=0", tick); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b want=0", running); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
`ifdef CLK_SCHED_SQUARE_EN
        checks++; if (clk_sq !== '0) begin failures++; $display("FAIL reset_clk_sq got=%b want=0", clk_sq); end
`endif
        reset = 1'b0;
        step();
        exp = '0;
        checks++; if (tick !== exp) begin failures++; $display("FAIL idle_tick got=%b want=%b", tick, exp); end
    endtask

    task automatic test_default_divs();
        logic [NUM_CH-1:0] exp;
        do_start();
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL arm_cfg_ready got=%b want=0", cfg_ready); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL arm_running got=%b want=0", running); end
        for (int k = 1; k <= 25; k++) exp_q.push_back((k % 10 == 0) ? 4'b1111 : 4'b0000);
        for (int k = 1; k <= 25; k++) begin
            step();
            exp = exp_q.pop_front();
            checks++; if (tick !== exp) begin failures++; $display("FAIL default_tick k=%0d got=%b want=%b", k, tick, exp); end
        end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL run_running got=%b want=1", running); end
        do_stop();
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_running got=%b want=0", running); end
    endtask

    task automatic test_idle_cfg();
        logic [NUM_CH-1:0] exp;
        cfg_write(2'd1, 16'd3);
        cfg_write(2'd2, 16'd1);
        cfg_write(2'd3, 16'd0);
        do_start();
        for (int k = 1; k <= 12; k++) begin
            exp = '0;
            exp[0] = (k % 10 == 0);
            exp[1] = (k % 3 == 0);
            exp[2] = 1'b1;
            exp[3] = 1'b0;
            exp_q.push_back(exp);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = exp_q.pop_front();
            checks++; if (tick !== exp) begin failures++; $display("FAIL idle_cfg_tick k=%0d got=%b want=%b", k, tick, exp); end
        end
        do_stop();
    endtask

    // Leaves the scheduler running at cycle 24 for the start/stop test.
    task automatic test_run_cfg();
        logic [NUM_CH-1:0] exp;
        do_start();
        for (int k = 1; k <= 24; k++) begin
            exp = '0;
            exp[0] = (k == 10) || (k > 10 && (k - 10) % 4 == 0);
            exp[1] = (k % 3 == 0);
            exp[2] = 1'b1;
            exp_q.push_back(exp);
        end
        for (int k = 1; k <= 24; k++) begin
            step();
            cfg_valid = 1'b0;
            exp = exp_q.pop_front();
            checks++; if (tick !== exp) begin failures++; $display("FAIL run_cfg_tick k=%0d got=%b want=%b", k, tick, exp); end
            if (k == 4) begin
                checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL run_cfg_ready got=%b want=1", cfg_ready); end
                cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
            end
        end
    endtask

    task automatic test_start_stop();
        logic [NUM_CH-1:0] exp;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL ss_running got=%b want=0", running); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (tick !== '0) begin failures++; $display("FAIL ss_tick k=%0d got=%b want=0", k, tick); end
            step();
        end
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL ss_idle_cfg_ready got=%b want=1", cfg_ready); end
        step();
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL ss_idle_running got=%b want=0", running); end
        do_start();
        for (int k = 1; k <= 8; k++) begin
            exp = '0;
            exp[0] = (k % 4 == 0);
            exp[1] = (k % 3 == 0);
            exp[2] = 1'b1;
            exp_q.push_back(exp);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = exp_q.pop_front();
            checks++; if (tick !== exp) begin failures++; $display("FAIL restart_tick k=%0d got=%b want=%b", k, tick, exp); end
        end
        do_stop();
    endtask

    task automatic test_reset_mid_run();
        logic [NUM_CH-1:0] exp;
        do_start();
        step(); step();
        cfg_write(2'd0, 16'd7);
        step(); step();
        checks++; if (tick === '0) begin failures++; $display("FAIL pre_reset_tick got=%b want=nonzero", tick); end
        reset = 1'b1;
        #1;
        checks++; if (tick !== '0) begin failures++; $display("FAIL mid_reset_tick got=%b want=0", tick); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL mid_reset_running got=%b want=0", running); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_cfg_ready got=%b want=1", cfg_ready); end
        step();
        reset = 1'b0;
        step();
        do_start();
        for (int k = 1; k <= 20; k++) exp_q.push_back((k % 10 == 0) ? 4'b1111 : 4'b0000);
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = exp_q.pop_front();
            checks++; if (tick !== exp) begin failures++; $display("FAIL post_reset_tick k=%0d got=%b want=%b", k, tick, exp); end
        end
        do_stop();
    endtask

`ifdef CLK_SCHED_SQUARE_EN
    task automatic test_square();
        logic exp_sq;
        cfg_write(2'd0, 16'd5);
        do_start();
        for (int k = 1; k <= 18; k++) begin
            step();
            exp_sq = (((k - 1) / 5) % 2) == 1;
            checks++; if (clk_sq[0] !== exp_sq) begin failures++; $display("FAIL square k=%0d got=%b want=%b", k, clk_sq[0], exp_sq); end
        end
        do_stop();
        checks++; if (clk_sq !== '0) begin failures++; $display("FAIL square_stop got=%b want=0", clk_sq); end
    endtask
`endif

    initial begin
        test_reset();
        test_default_divs();
        test_idle_cfg();
        test_run_cfg();
        test_start_stop();
        test_reset_mid_run();
`ifdef CLK_SCHED_SQUARE_EN
        test_square();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
